sensor_gate_ctrl: RTL and testbench
===================================

# sensor_gate_ctrl

Parametrised, clocked sensor-driven gating controller for the vga_lcd power-control path. It takes NUM_SENSORS raw sensor lines and applies a per-channel glitch filter. A per-channel minimum-hold/cool-down state machine then produces registered isolation/sleep-gate outputs. It also forms NUM_GROUPS programmable AND-combinations of those gates and keeps a saturating count of gate activations.

## Interface
- NUM_SENSORS, 10: number of sensor/gate channels (≥1).
- NUM_GROUPS, 4: number of programmable AND-combination outputs (≥1).
- FILT_CYC, 2: consecutive cycles a sampled sensor value must differ from the filtered value before the filtered value changes (≥1).
- HOLD_CYC, 4: minimum cycles a gate stays asserted once asserted (≥1).
- COOL_CYC, 2: cycles a gate is held deasserted and ignores its sensor after release (≥0).
- CNT_W, 16: activation counter width.
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- vdd  in  1  global enable; 0 forces all gates off.
- sensor  in  NUM_SENSORS  raw sensor lines, bit i = channel i.
- grp_mask  in  NUM_GROUPS*NUM_SENSORS  group g uses bits [g*NUM_SENSORS +: NUM_SENSORS]; bit set = channel included.
- clr_cnt  in  1  synchronous clear of act_cnt.
- isg  out  NUM_SENSORS  registered per-channel gate.
- grp_sg  out  NUM_GROUPS  registered AND of masked isg bits.
- act_cnt  out  CNT_W  saturating count of gate activations.

## Operation
- Input stage: s_q <= sensor every edge. No behaviour is defined for sensor changes within a cycle.
- Filter, per channel:
  - filt and counter fcnt, width clog2(FILT_CYC)+1.
  - If s_q == filt: fcnt <= 0.
  - Else if fcnt == FILT_CYC-1: filt <= s_q and fcnt <= 0.
  - Else: fcnt++.
  - Any return of s_q to filt before the filter commits restarts the count.
  - The filter runs regardless of vdd.
- Channel FSM, per channel, states IDLE, ON, COOL:
  - IDLE (isg=0): if vdd && filt, go to ON and load hold <= HOLD_CYC-1.
  - ON (isg=1): if hold != 0, hold--. If hold == 0 && !filt, go to COOL and load cool <= COOL_CYC-1; if COOL_CYC == 0, go directly to IDLE.
  - COOL (isg=0): the sensor is ignored. If cool == 0, go to IDLE; else cool--.
  - isg = (state == ON), registered (state-encoded).
- vdd == 0 at any edge: every FSM goes to IDLE and hold/cool are zeroed at that edge. isg is 0 after that edge, and act_cnt does not increment.
- Groups: grp_sg[g] <= |mask_g && &(isg | ~mask_g). An all-zero mask gives 0. The mask is sampled at the same edge as the isg it combines with (registered isg plus registered combine).
- Counter:
  - inc = number of channels making an IDLE->ON transition at this edge (popcount).
  - act_cnt <= min(act_cnt + inc, 2^CNT_W-1).
  - clr_cnt has priority: act_cnt <= 0 and that cycle's inc is discarded.

## Timing
- Reset values: isg=0, grp_sg=0, act_cnt=0. Also filt=0, s_q=0, fcnt=0, all FSMs IDLE.
- Sensor-to-gate latency, with the sensor changing before edge 0 and held:
  - s_q at edge 0.
  - filt at edge FILT_CYC.
  - isg at edge FILT_CYC+1.
  - grp_sg and act_cnt at edge FILT_CYC+2 and FILT_CYC+1 respectively.
- Deassertion uses the same filter latency. In addition, isg stays high at least HOLD_CYC cycles measured from its rising edge.
- Re-arm: after isg falls, it cannot rise again for COOL_CYC+1 edges (COOL_CYC in COOL plus one in IDLE).
- Simultaneous events:
  - Filter commit and FSM exit evaluate the filt value registered before the edge.
  - vdd=0 overrides all transitions.
  - rst overrides everything, including clr_cnt.
- Reset mid-operation: all state returns to reset values at that edge, and no activation is counted.
- Saturation: act_cnt holds at all-ones; further activations are dropped silently.

## Test plan
- Defaults, vdd=1, sensor[3] pulsed high for 1 cycle, then for 2 cycles -> 1-cycle pulse: no isg change. 2-cycle pulse: isg[3] rises at edge 3 after sampling, stays high exactly 4 cycles, act_cnt=1.
- sensor[0] high for 20 cycles, then low; mask0=channel 0 only -> isg[0] falls 3 edges after sensor falls. isg[0] ignores a sensor re-pulse during its 2 COOL cycles. grp_sg[0] tracks isg[0] delayed 1 cycle.
- Channels 5..9 raised together, mask1=0x3E0 -> grp_sg[1]=1 only while all five isg are high. Dropping sensor[7] clears grp_sg[1] after the filter, FSM and group delays. act_cnt increments by 5 at once.
- vdd pulled to 0 while channels are ON -> isg=0, grp_sg=0 next edge, act_cnt frozen. vdd restored with sensors still high -> gates reassert next edge (filt already 1) and act_cnt increments.
- CNT_W=3 with repeated activations reaching 7, then more -> act_cnt stays 7. clr_cnt asserted on the same cycle as an activation -> act_cnt=0.
- rst asserted mid-HOLD with sensors high -> all outputs 0 at that edge. After rst drops, isg rises at edge FILT_CYC+1 after release.

Source files
------------

// File: rtl/sensor_gate_ctrl.sv
// Sensor-driven isolation/sleep gating: per-channel glitch filter, minimum-hold and
// cool-down FSM, programmable AND groups of gates, and a saturating activation counter.
module sensor_gate_ctrl #(
  parameter int NUM_SENSORS = 10,
  parameter int NUM_GROUPS  = 4,
  parameter int FILT_CYC    = 2,
  parameter int HOLD_CYC    = 4,
  parameter int COOL_CYC    = 2,
  parameter int CNT_W       = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              vdd,
  input  logic [NUM_SENSORS-1:0]            sensor,
  input  logic [NUM_GROUPS*NUM_SENSORS-1:0] grp_mask,
  input  logic                              clr_cnt,
  output logic [NUM_SENSORS-1:0]            isg,
  output logic [NUM_GROUPS-1:0]             grp_sg,
  output logic [CNT_W-1:0]                  act_cnt
);

  localparam int FCNT_W = $clog2(FILT_CYC) + 1;
  localparam int HOLD_W = $clog2(HOLD_CYC) + 1;
  localparam int COOL_W = $clog2(COOL_CYC + 1) + 1;
  localparam int INC_W  = $clog2(NUM_SENSORS + 1);
  localparam int SUM_W  = CNT_W + INC_W;

  localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(FILT_CYC - 1);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYC - 1);
  localparam logic [COOL_W-1:0] COOL_LOAD = COOL_W'((COOL_CYC > 0) ? COOL_CYC - 1 : 0);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_COOL = 2'd2
  } state_t;

  logic [NUM_SENSORS-1:0]             r_s_q;
  logic [NUM_SENSORS-1:0]             r_filt;
  logic [NUM_SENSORS-1:0][FCNT_W-1:0] r_fcnt;
  state_t                             r_state     [NUM_SENSORS];
  state_t                             w_state_nxt [NUM_SENSORS];
  logic [NUM_SENSORS-1:0][HOLD_W-1:0] r_hold, w_hold_nxt;
  logic [NUM_SENSORS-1:0][COOL_W-1:0] r_cool, w_cool_nxt;
  logic [NUM_SENSORS-1:0]             w_act;
  logic [INC_W-1:0]                   w_inc;
  logic [SUM_W-1:0]                   w_sum;
  logic [NUM_GROUPS-1:0]              w_grp_nxt;
  logic [NUM_GROUPS-1:0]              r_grp_sg;
  logic [CNT_W-1:0]                   r_act_cnt;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s_q  <= '0;
      r_filt <= '0;
      r_fcnt <= '0;
    end else begin
      r_s_q <= sensor;
      for (int i = 0; i < NUM_SENSORS; i++) begin
        if (r_s_q[i] == r_filt[i]) begin
          r_fcnt[i] <= '0;
        end else if (r_fcnt[i] == FCNT_LAST) begin
          r_filt[i] <= r_s_q[i];
          r_fcnt[i] <= '0;
        end else begin
          r_fcnt[i] <= r_fcnt[i] + FCNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_SENSORS; i++) r_state[i] <= ST_IDLE;
      r_hold <= '0;
      r_cool <= '0;
    end else begin
      for (int i = 0; i < NUM_SENSORS; i++) r_state[i] <= w_state_nxt[i];
      r_hold <= w_hold_nxt;
      r_cool <= w_cool_nxt;
    end
  end

  // NOTE: every comb output is given a default before the case so no latch is inferred.
  always_comb begin
    w_hold_nxt = r_hold;
    w_cool_nxt = r_cool;
    for (int i = 0; i < NUM_SENSORS; i++) begin
      w_state_nxt[i] = r_state[i];
      if (!vdd) begin
        w_state_nxt[i] = ST_IDLE;
        w_hold_nxt[i]  = '0;
        w_cool_nxt[i]  = '0;
      end else begin
        case (r_state[i])
          ST_IDLE: begin
            if (r_filt[i]) begin
              w_state_nxt[i] = ST_ON;
              w_hold_nxt[i]  = HOLD_LOAD;
            end
          end
          ST_ON: begin
            if (r_hold[i] != '0) begin
              w_hold_nxt[i] = r_hold[i] - HOLD_W'(1);
            end else if (!r_filt[i]) begin
              if (COOL_CYC == 0) begin
                w_state_nxt[i] = ST_IDLE;
              end else begin
                w_state_nxt[i] = ST_COOL;
                w_cool_nxt[i]  = COOL_LOAD;
              end
            end
          end
          ST_COOL: begin
            // Sensor is deliberately ignored while cooling down.
            if (r_cool[i] == '0) w_state_nxt[i] = ST_IDLE;
            else                 w_cool_nxt[i]  = r_cool[i] - COOL_W'(1);
          end
          default: w_state_nxt[i] = ST_IDLE;
        endcase
      end
    end
  end

  always_comb begin
    isg   = '0;
    w_act = '0;
    for (int i = 0; i < NUM_SENSORS; i++) begin
      isg[i]   = (r_state[i] == ST_ON);
      w_act[i] = (r_state[i] == ST_IDLE) && (w_state_nxt[i] == ST_ON);
    end
  end

  always_comb begin
    w_inc = '0;
    for (int i = 0; i < NUM_SENSORS; i++) w_inc = w_inc + INC_W'(w_act[i]);
  end

  assign w_sum = SUM_W'(r_act_cnt) + SUM_W'(w_inc);

  for (genvar g = 0; g < NUM_GROUPS; g++) begin : g_grp
    assign w_grp_nxt[g] = (|grp_mask[g*NUM_SENSORS +: NUM_SENSORS]) &&
                          (&(isg | ~grp_mask[g*NUM_SENSORS +: NUM_SENSORS]));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_grp_sg  <= '0;
      r_act_cnt <= '0;
    end else begin
      r_grp_sg <= w_grp_nxt;
      if (clr_cnt)                       r_act_cnt <= '0;
      else if (w_sum > SUM_W'(CNT_MAX))  r_act_cnt <= CNT_MAX;
      else                               r_act_cnt <= w_sum[CNT_W-1:0];
    end
  end

  assign grp_sg  = r_grp_sg;
  assign act_cnt = r_act_cnt;

endmodule

// File: tb/tb_sensor_gate_ctrl.sv
// Self-checking bench for sensor_gate_ctrl: directed scenarios plus randomized traffic,
// compared every cycle against a timestamp-based reference model.
module tb_sensor_gate_ctrl;

  localparam int N    = 10;
  localparam int G    = 4;
  localparam int FILT = 2;
  localparam int HOLD = 4;
  localparam int COOL = 2;
  localparam longint CNT_MAX   = 64'hFFFF;
  localparam longint CNT_MAX_S = 7;

  logic           clk;
  logic           rst;
  logic           vdd;
  logic [N-1:0]   sensor;
  logic [G*N-1:0] grp_mask;
  logic           clr_cnt;
  logic [N-1:0]   isg, isg_s;
  logic [G-1:0]   grp_sg, grp_sg_s;
  logic [15:0]    act_cnt;
  logic [2:0]     act_cnt_s;

  sensor_gate_ctrl u_dut (
    .clk(clk), .rst(rst), .vdd(vdd), .sensor(sensor), .grp_mask(grp_mask),
    .clr_cnt(clr_cnt), .isg(isg), .grp_sg(grp_sg), .act_cnt(act_cnt)
  );

  sensor_gate_ctrl #(.CNT_W(3)) u_dut_s (
    .clk(clk), .rst(rst), .vdd(vdd), .sensor(sensor), .grp_mask(grp_mask),
    .clr_cnt(clr_cnt), .isg(isg_s), .grp_sg(grp_sg_s), .act_cnt(act_cnt_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: filter as a run length of disagreement, gate as rise/ready timestamps.
  bit [N-1:0] m_sq, m_filt, m_gate;
  int         m_run   [N];
  int         m_rise  [N];
  int         m_ready [N];
  bit [G-1:0] m_grp;
  longint     m_cnt, m_cnt_s;
  int         m_edge;

  task automatic model_step();
    bit [N-1:0] old_gate, old_filt, old_sq, mk;
    int inc;
    old_gate = m_gate;
    old_filt = m_filt;
    old_sq   = m_sq;
    inc      = 0;
    m_edge++;
    if (rst) begin
      m_sq = '0; m_filt = '0; m_gate = '0; m_grp = '0; m_cnt = 0; m_cnt_s = 0;
      for (int i = 0; i < N; i++) begin
        m_run[i] = 0; m_rise[i] = 0; m_ready[i] = 0;
      end
      return;
    end
    for (int g = 0; g < G; g++) begin
      mk = grp_mask[g*N +: N];
      m_grp[g] = (mk != '0) && ((old_gate & mk) == mk);
    end
    for (int i = 0; i < N; i++) begin
      if (!vdd) begin
        m_gate[i]  = 1'b0;
        m_ready[i] = m_edge + 1;
      end else if (!old_gate[i]) begin
        if (m_edge >= m_ready[i] && old_filt[i]) begin
          m_gate[i] = 1'b1;
          m_rise[i] = m_edge;
          inc++;
        end
      end else if (m_edge >= m_rise[i] + HOLD && !old_filt[i]) begin
        m_gate[i]  = 1'b0;
        m_ready[i] = m_edge + COOL + 1;
      end
      if (old_sq[i] == old_filt[i]) begin
        m_run[i] = 0;
      end else begin
        m_run[i]++;
        if (m_run[i] == FILT) begin
          m_filt[i] = old_sq[i];
          m_run[i]  = 0;
        end
      end
    end
    m_sq = sensor;
    if (clr_cnt) begin
      m_cnt = 0; m_cnt_s = 0;
    end else begin
      m_cnt   = (m_cnt + inc > CNT_MAX) ? CNT_MAX : m_cnt + inc;
      m_cnt_s = (m_cnt_s + inc > CNT_MAX_S) ? CNT_MAX_S : m_cnt_s + inc;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check("isg",       64'(isg),       64'(m_gate));
    check("grp_sg",    64'(grp_sg),    64'(m_grp));
    check("act_cnt",   64'(act_cnt),   64'(m_cnt));
    check("act_cnt_s", 64'(act_cnt_s), 64'(m_cnt_s));
  endtask

  longint base;

  initial begin
    rst = 1'b1; vdd = 1'b1; sensor = '0; grp_mask = '0; clr_cnt = 1'b0;
    m_edge = 0;
    repeat (2) tick();
    check("rst_isg", 64'(isg), 64'd0);
    check("rst_grp", 64'(grp_sg), 64'd0);
    check("rst_cnt", 64'(act_cnt), 64'd0);
    rst = 1'b0;
    tick();

    // 1-cycle glitch on channel 3 is filtered out
    sensor[3] = 1'b1; tick();
    sensor[3] = 1'b0;
    repeat (8) begin tick(); check("glitch_isg", 64'(isg), 64'd0); end

    // 2-cycle pulse: rise at edge 3, high exactly HOLD cycles
    sensor[3] = 1'b1; tick(); tick();
    sensor[3] = 1'b0; tick();
    check("p2_e2_isg", 64'(isg[3]), 64'd0);
    tick();
    check("p2_rise", 64'(isg[3]), 64'd1);
    check("p2_cnt", 64'(act_cnt), 64'd1);
    repeat (3) begin tick(); check("p2_hold", 64'(isg[3]), 64'd1); end
    tick();
    check("p2_fall", 64'(isg[3]), 64'd0);
    repeat (4) tick();

    // Long sensor[0], group 0 = channel 0 only
    grp_mask = {30'h0, 10'h001};
    sensor[0] = 1'b1;
    repeat (20) tick();
    sensor[0] = 1'b0;
    tick(); tick(); tick();
    check("long_e22_isg", 64'(isg[0]), 64'd1);
    sensor[0] = 1'b1;
    tick();
    check("long_fall", 64'(isg[0]), 64'd0);
    check("long_grp_lag", 64'(grp_sg[0]), 64'd1);
    tick();
    check("cool_ignore0", 64'(isg[0]), 64'd0);
    check("long_grp_off", 64'(grp_sg[0]), 64'd0);
    sensor[0] = 1'b0;
    tick();
    check("cool_ignore1", 64'(isg[0]), 64'd0);
    repeat (12) tick();

    // Channels 5..9 together, group 1 = 0x3E0
    grp_mask = {20'h0, 10'h3E0, 10'h001};
    base = m_cnt;
    sensor[9:5] = 5'h1F;
    tick(); tick(); tick();
    check("g1_e2", 64'(grp_sg[1]), 64'd0);
    tick();
    check("g1_isg", 64'(isg[9:5]), 64'h1F);
    check("g1_cnt5", 64'(act_cnt), 64'(base + 5));
    check("g1_e3", 64'(grp_sg[1]), 64'd0);
    tick();
    check("g1_on", 64'(grp_sg[1]), 64'd1);
    sensor[7] = 1'b0;
    tick(); tick(); tick();
    check("g1_e7_isg7", 64'(isg[7]), 64'd1);
    tick();
    check("g1_e8_isg7", 64'(isg[7]), 64'd0);
    check("g1_e8_grp", 64'(grp_sg[1]), 64'd1);
    tick();
    check("g1_e9_grp", 64'(grp_sg[1]), 64'd0);
    repeat (6) tick();

    // vdd drop while channels 5,6,8,9 are ON, then restore
    base = m_cnt;
    vdd = 1'b0; tick();
    check("vdd_off_isg", 64'(isg), 64'd0);
    check("vdd_off_cnt", 64'(act_cnt), 64'(base));
    tick();
    check("vdd_off_grp", 64'(grp_sg), 64'd0);
    vdd = 1'b1; tick();
    check("vdd_on_isg", 64'(isg[9:5]), 64'h1B);
    check("vdd_on_cnt", 64'(act_cnt), 64'(base + 4));

    // Small counter is saturated; clr_cnt wins over a same-cycle activation
    check("sat_hold", 64'(act_cnt_s), 64'd7);
    vdd = 1'b0; tick();
    vdd = 1'b1; clr_cnt = 1'b1; tick();
    check("clr_cnt", 64'(act_cnt), 64'd0);
    check("clr_cnt_s", 64'(act_cnt_s), 64'd0);
    clr_cnt = 1'b0;
    repeat (3) begin vdd = 1'b0; tick(); vdd = 1'b1; tick(); end
    check("resat_s", 64'(act_cnt_s), 64'd7);
    check("resat_big", 64'(act_cnt), 64'd12);

    // Reset mid-hold with sensors still high
    vdd = 1'b0; tick();
    vdd = 1'b1; tick(); tick();
    rst = 1'b1; tick();
    check("mrst_isg", 64'(isg), 64'd0);
    check("mrst_grp", 64'(grp_sg), 64'd0);
    check("mrst_cnt", 64'(act_cnt), 64'd0);
    rst = 1'b0;
    tick(); tick(); tick();
    check("mrst_e2", 64'(isg), 64'd0);
    tick();
    check("mrst_e3", 64'(isg[9:5]), 64'h1B);

    // Randomized traffic
    for (int c = 0; c < 2000; c++) begin
      for (int i = 0; i < N; i++) if ($urandom_range(5) == 0) sensor[i] = ~sensor[i];
      vdd     = ($urandom_range(39) != 0);
      clr_cnt = ($urandom_range(49) == 0);
      rst     = ($urandom_range(299) == 0);
      if ($urandom_range(99) == 0) begin
        for (int g = 0; g < G; g++) begin
          grp_mask[g*N +: N] = N'($urandom) & N'($urandom) & N'($urandom);
        end
      end
      tick();
    end
    rst = 1'b0; clr_cnt = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
